// File: rtl/branch_controller.sv
// Bimodal branch-direction predictor for the 5-stage core.
// Decode gets a same-cycle prediction and recovery target.
// Execute trains a table of 2-bit saturating counters indexed by word PC.
module branch_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // decode side
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_valid,
  input  logic                  dec_is_jump,
  input  logic [ADDR_WIDTH-1:0] dec_target,
  output logic                  dec_prediction,
  output logic [ADDR_WIDTH-1:0] dec_recovery_target,
  // execute side
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_valid,
  input  logic                  ex_outcome,
  input  logic                  ex_prediction,
  input  logic [ADDR_WIDTH-1:0] ex_recovery_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht_q [ENTRIES];
  logic [1:0]            bht_d [ENTRIES];
  logic [INDEX_BITS-1:0] dec_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [1:0]            ex_ctr;
  logic [ADDR_WIDTH-1:0] dec_pc_plus8;

  // Low two PC bits are always zero (word-aligned); high bits alias freely.
  assign dec_idx      = dec_pc[INDEX_BITS+1:2];
  assign ex_idx       = ex_pc[INDEX_BITS+1:2];
  assign ex_ctr       = bht_q[ex_idx];
  assign dec_pc_plus8 = dec_pc + ADDR_WIDTH'(8);

  // Execute carries the resolved prediction/recovery too; nothing here needs them.
  logic unused_ok;
  assign unused_ok = ^{ex_prediction, ex_recovery_target,
                       dec_pc[1:0], dec_pc[ADDR_WIDTH-1:INDEX_BITS+2],
                       ex_pc[1:0], ex_pc[ADDR_WIDTH-1:INDEX_BITS+2]};

  // Next table contents: saturating increment/decrement of the resolved entry.
  always_comb begin
    bht_d = bht_q;
    if (ex_valid) begin
      if (ex_outcome) begin
        if (ex_ctr != 2'd3) bht_d[ex_idx] = ex_ctr + 2'd1;
      end else begin
        if (ex_ctr != 2'd0) bht_d[ex_idx] = ex_ctr - 2'd1;
      end
    end
  end

  // Table storage; reset parks every entry at weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'd1;
    end else begin
      bht_q <= bht_d;
    end
  end

  // Zero-latency prediction from the registered table; no bypass of a same-cycle update.
  always_comb begin
    dec_prediction      = 1'b0;
    dec_recovery_target = dec_pc_plus8;
    if (dec_valid) begin
      if (dec_is_jump) begin
        dec_prediction = 1'b1;
      end else if (bht_q[dec_idx][1]) begin
        dec_prediction = 1'b1;
      end else begin
        dec_recovery_target = dec_target;
      end
    end
  end

endmodule

// File: tb/tb_branch_controller.sv
// Directed bench for branch_controller: training, saturation, jumps,
// same-cycle read/update ordering, aliasing and asynchronous reset.
module tb_branch_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] dec_pc;
  logic        dec_valid;
  logic        dec_is_jump;
  logic [31:0] dec_target;
  logic        dec_prediction;
  logic [31:0] dec_recovery_target;
  logic [31:0] ex_pc;
  logic        ex_valid;
  logic        ex_outcome;
  logic        ex_prediction;
  logic [31:0] ex_recovery_target;

  int n_tests = 0;
  int n_fail  = 0;

  branch_controller #(.ADDR_WIDTH(32), .INDEX_BITS(8)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dec_pc              (dec_pc),
    .dec_valid           (dec_valid),
    .dec_is_jump         (dec_is_jump),
    .dec_target          (dec_target),
    .dec_prediction      (dec_prediction),
    .dec_recovery_target (dec_recovery_target),
    .ex_pc               (ex_pc),
    .ex_valid            (ex_valid),
    .ex_outcome          (ex_outcome),
    .ex_prediction       (ex_prediction),
    .ex_recovery_target  (ex_recovery_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic decode(input logic [31:0] pc, input logic jump, input logic [31:0] tgt);
    dec_pc      = pc;
    dec_valid   = 1'b1;
    dec_is_jump = jump;
    dec_target  = tgt;
  endtask

  // Hold one resolved branch on the execute port for n rising edges.
  task automatic ex_train(input logic [31:0] pc, input logic taken, input int n);
    ex_pc      = pc;
    ex_outcome = taken;
    ex_valid   = 1'b1;
    repeat (n) @(negedge clk);
    ex_valid   = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic pred, input logic [31:0] rt);
    #1;
    check({tag, "_pred"}, {31'd0, dec_prediction}, {31'd0, pred});
    check({tag, "_rt"}, dec_recovery_target, rt);
  endtask

  initial begin
    rst_n = 1'b0;
    dec_pc = '0; dec_valid = 1'b0; dec_is_jump = 1'b0; dec_target = '0;
    ex_pc = '0; ex_valid = 1'b0; ex_outcome = 1'b0;
    ex_prediction = 1'b0; ex_recovery_target = '0;

    // outputs are live during reset
    decode(32'h0040_0010, 1'b0, 32'h0040_0100);
    expect_pred("in_reset", 1'b0, 32'h0040_0100);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_pred("post_reset", 1'b0, 32'h0040_0100);

    // not-valid decode: NT, fall-through
    dec_valid = 1'b0;
    expect_pred("no_valid", 1'b0, 32'h0040_0018);

    // two TAKEN: 1 -> 3
    ex_train(32'h0040_0010, 1'b1, 2);
    decode(32'h0040_0010, 1'b0, 32'h0040_0100);
    expect_pred("trained_t", 1'b1, 32'h0040_0018);

    // one more TAKEN (sat 3), one NOT_TAKEN -> 2
    ex_train(32'h0040_0010, 1'b1, 1);
    ex_train(32'h0040_0010, 1'b0, 1);
    expect_pred("weak_t", 1'b1, 32'h0040_0018);

    // one more NT -> 1, flips prediction; then TAKEN back to 2
    ex_train(32'h0040_0010, 1'b0, 1);
    expect_pred("back_to_nt", 1'b0, 32'h0040_0100);
    ex_train(32'h0040_0010, 1'b1, 1);

    // five NT saturate at 0, one TAKEN -> 1
    decode(32'h0040_0020, 1'b0, 32'h0040_0200);
    ex_train(32'h0040_0020, 1'b0, 5);
    expect_pred("sat0", 1'b0, 32'h0040_0200);
    ex_train(32'h0040_0020, 1'b1, 1);
    expect_pred("sat0_plus1", 1'b0, 32'h0040_0200);
    // a second TAKEN would reach 2 only if the floor held at 0 -> 1 -> 2
    ex_train(32'h0040_0020, 1'b1, 1);
    expect_pred("sat0_plus2", 1'b1, 32'h0040_0028);

    // jump: always taken, does not touch the table
    decode(32'h0040_0030, 1'b1, 32'h0040_0300);
    expect_pred("jump", 1'b1, 32'h0040_0038);
    @(negedge clk);
    decode(32'h0040_0030, 1'b0, 32'h0040_0300);
    expect_pred("after_jump", 1'b0, 32'h0040_0300);

    // jump with PC wrap
    decode(32'hFFFF_FFFC, 1'b1, 32'h0000_1000);
    expect_pred("jump_wrap", 1'b1, 32'h0000_0004);

    // same-cycle read/update: old value this cycle, new value next
    decode(32'h0040_0040, 1'b0, 32'h0040_0400);
    ex_pc = 32'h0040_0040; ex_outcome = 1'b1; ex_valid = 1'b1;
    expect_pred("conflict_now", 1'b0, 32'h0040_0400);
    @(negedge clk);
    ex_valid = 1'b0;
    expect_pred("conflict_next", 1'b1, 32'h0040_0048);

    // aliasing: 0x0040_0010 is at 2, train to 3; 0x0040_0410 shares the entry
    ex_train(32'h0040_0010, 1'b1, 1);
    decode(32'h0040_0410, 1'b0, 32'h0040_0500);
    expect_pred("alias", 1'b1, 32'h0040_0418);

    // async reset between edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_pred("async_rst", 1'b0, 32'h0040_0500);
    @(negedge clk);
    rst_n = 1'b1;
    decode(32'h0040_0040, 1'b0, 32'h0040_0400);
    expect_pred("rst_cleared", 1'b0, 32'h0040_0400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
